// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared defaults and verification helper for seq_detector
// Contents:
//   DEF_PAT_W, DEF_PATTERN - default pattern configuration (1101)
//   f_self_overlap         - smallest nonzero shift at which a pattern overlaps
//                            itself; returns pat_w when there is no overlap
package seq_detector_pkg;

    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;

    function automatic int f_self_overlap(input logic [15:0] pattern, input int pat_w);
        int   res;
        logic ok;
        res = pat_w;
        // Walk shifts downward so the smallest overlapping shift is the last one kept
        for (int s = pat_w - 1; s >= 1; s--) begin
            ok = 1'b1;
            for (int i = 0; i + s < pat_w; i++)
                if (pattern[i] != pattern[i+s]) ok = 1'b0;
            if (ok) res = s;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector.sv
// seq_detector: serial bit-pattern detector with registered match pulse and saturating match count
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   in        - serial data bit, sampled every rising edge
//   out       - one-cycle match flag, registered
//   match_cnt - matches since reset, saturating at all-ones
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $error("seq_detector: PAT_W must be within 2..16");
    end

    // Only the youngest PAT_W-1 bits are stored; the full window is those plus the new bit
    logic [PAT_W-2:0]  hist_q;
    logic [PAT_W-1:0]  hist_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_sat;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q, hit;

    always_comb begin
        hist_d   = {hist_q, in};
        fill_sat = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hit      = (fill_sat == FULL) && (hist_d == PATTERN);
        // Without overlap, the match consumes the window so PAT_W fresh bits are needed again
        fill_d   = (hit && !OVERLAP) ? '0 : fill_sat;
        cnt_d    = (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d[PAT_W-2:0];
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            out_q  <= hit;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: scoreboard bench over four seq_detector configurations sharing one input stream
module tb_seq_detector;
    import seq_detector_pkg::*;

    typedef struct packed {
        logic [3:0]      o;
        logic [3:0][7:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       o0, o1, o2, o3;
    logic [7:0] c0, c1, c3;
    logic [1:0] c2;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic [3:0] pat [4] = '{4'b1101, 4'b1101, 4'b1101, 4'b1111};
    bit         ovl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int         cmax[4] = '{255, 255, 3, 255};
    bit         hb  [4][64];
    int         len [4];
    int         mcnt[4];
    int         pulses[4];

    always #5 clk = ~clk;

    seq_detector u0 (.clk(clk), .rst(rst), .in(din), .out(o0), .match_cnt(c0));
    seq_detector #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .in(din), .out(o1), .match_cnt(c1));
    seq_detector #(.OVERLAP(1'b0), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .in(din), .out(o2), .match_cnt(c2));
    seq_detector #(.PATTERN(4'b1111)) u3 (.clk(clk), .rst(rst), .in(din), .out(o3), .match_cnt(c3));

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: bits since the last clear; a match is the newest four equal to the pattern
    task automatic model(input bit r, input bit b, output exp_t e);
        bit hit;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                len[k]  = 0;
                mcnt[k] = 0;
                hit     = 1'b0;
            end else begin
                hb[k][len[k] % 64] = b;
                len[k]++;
                hit = (len[k] >= 4);
                for (int j = 0; j < 4; j++)
                    if (len[k] >= 4 && hb[k][(len[k] - 1 - j) % 64] != pat[k][j]) hit = 1'b0;
                if (hit) begin
                    if (mcnt[k] < cmax[k]) mcnt[k]++;
                    if (!ovl[k]) len[k] = 0;
                end
            end
            e.o[k] = hit;
            e.c[k] = 8'(mcnt[k]);
        end
    endtask

    task automatic step(input bit r, input bit b);
        exp_t e;
        @(negedge clk);
        rst = r;
        din = b;
        model(r, b, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out0", int'(o0), int'(e.o[0]));
        chk("out1", int'(o1), int'(e.o[1]));
        chk("out2", int'(o2), int'(e.o[2]));
        chk("out3", int'(o3), int'(e.o[3]));
        chk("cnt0", int'(c0), int'(e.c[0]));
        chk("cnt1", int'(c1), int'(e.c[1]));
        chk("cnt2", int'(c2), int'(e.c[2]));
        chk("cnt3", int'(c3), int'(e.c[3]));
        pulses[0] += int'(o0);
        pulses[1] += int'(o1);
        pulses[2] += int'(o2);
        pulses[3] += int'(o3);
    endtask

    task automatic drive(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b0, s[i] == "1");
    endtask

    task automatic do_reset(input bit b);
        step(1'b1, b);
        for (int k = 0; k < 4; k++) pulses[k] = 0;
    endtask

    initial begin
        chk("ovl_1101", f_self_overlap(16'b1101, 4), 3);
        chk("ovl_1111", f_self_overlap(16'b1111, 4), 1);
        chk("ovl_1000", f_self_overlap(16'b1000, 4), 4);

        do_reset(1'b1);
        drive("0110110");
        chk("basic_cnt0", int'(c0), 1);
        chk("basic_pulses0", pulses[0], 1);

        do_reset(1'b0);
        drive("1101101");
        chk("ovl_cnt0", int'(c0), 2);
        chk("novl_cnt1", int'(c1), 1);
        chk("ovl_pulses0", pulses[0], 2);

        do_reset(1'b0);
        drive("110");
        do_reset(1'b1);
        drive("1");
        chk("midrst_pulses0", pulses[0], 0);
        drive("1101");
        chk("midrst_after_cnt0", int'(c0), 1);
        chk("midrst_after_pulses0", pulses[0], 1);

        do_reset(1'b0);
        drive("11011101110111011101");
        chk("sat_cnt2", int'(c2), 3);
        chk("sat_pulses2", pulses[2], 5);
        chk("sat_cnt1", int'(c1), 5);

        do_reset(1'b0);
        drive("111111");
        chk("self_pulses3", pulses[3], 3);
        chk("self_cnt3", int'(c3), 3);
        drive("0");
        chk("self_end_out3", int'(o3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
